weight_load_ctrl: RTL

Double-buffered weight loader for the conv/MLP datapath: receives packed weight words over an internal write-side FIFO, unpacks them into WEIGHT_WIDTH-bit weights, and fills the shadow bank of a two-bank R×S weight store while the compute array reads the active bank. It generalises single-bank weight loading with:
- configurable word packing and filter size up to MAX_R×MAX_S;
- bank ping-pong via SWAP;
- abort/clear and parameter checking.

---
 rtl/weight_load_ctrl_if.sv | 21 ++
 rtl/weight_load_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl_if.sv
// Write-side FIFO port of the weight loader: pushes from mem_ctrl, occupancy back.
interface weight_load_ctrl_if #(
   parameter int INPUT_WIDTH = 32,
   parameter int FIFO_DEPTH  = 16
);
   logic                          FIFO_WR_CMD;
   logic [INPUT_WIDTH-1:0]        FIFO_WR_DATA;
   logic                          FIFO_EMPTY;
   logic                          FIFO_FULL;
   logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT;

   modport master (
      output FIFO_WR_CMD, FIFO_WR_DATA,
      input  FIFO_EMPTY, FIFO_FULL, FIFO_COUNT
   );

   modport slave (
      input  FIFO_WR_CMD, FIFO_WR_DATA,
      output FIFO_EMPTY, FIFO_FULL, FIFO_COUNT
   );
endinterface

// File: rtl/weight_load_ctrl.sv
// Double-buffered R x S weight store: unpacks FIFO words into the shadow bank
// while the compute array reads the active bank; SWAP flips the banks.
//
// state | meaning
// IDLE  | no load running; SWAP and LOAD_START edges are accepted
// LOAD  | popping FIFO words into the shadow bank until N weights are written
module weight_load_ctrl #(
   parameter int INPUT_WIDTH  = 32,
   parameter int WEIGHT_WIDTH = 8,
   parameter int MAX_R        = 5,
   parameter int MAX_S        = 5,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                                  CLK,
   input  logic                                  RESETN,
   input  logic                                  CLEAR,
   input  logic                                  LOAD_START,
   input  logic [3:0]                            PARAM_R,
   input  logic [3:0]                            PARAM_S,
   input  logic                                  SWAP,
   output logic                                  LOADING,
   output logic                                  LOAD_DONE,
   output logic                                  SHADOW_VALID,
   output logic                                  ACTIVE_BANK,
   output logic                                  ERR_PARAM,
   output logic [MAX_R*MAX_S*WEIGHT_WIDTH-1:0]   WS_RD_DATA,
   weight_load_ctrl_if.slave                     fifo_if
);
   localparam int WPW   = INPUT_WIDTH / WEIGHT_WIDTH;
   localparam int NSLOT = MAX_R * MAX_S;
   localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam int IW    = $clog2(NSLOT + WPW) + 1;
   localparam logic [3:0] R_MAX4 = 4'(MAX_R);
   localparam logic [3:0] S_MAX4 = 4'(MAX_S);

   typedef enum logic {IDLE, LOAD} state_t;

   state_t                           state;
   logic                             start_prev, clr_prev;
   logic                             start_edge, clr_edge;
   logic                             param_ok;
   logic [3:0]                       s_lat;
   logic [IW-1:0]                    n_lat, w_idx;
   logic [3:0]                       r_cnt, c_cnt;
   logic [NSLOT-1:0][WEIGHT_WIDTH-1:0] bank [2];
   logic                             active_bank, shadow_valid, err_param, load_done;
   logic                             sh;

   logic [INPUT_WIDTH-1:0]           fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]                    wr_ptr, rd_ptr;
   logic [CW-1:0]                    fifo_cnt;
   logic                             fifo_empty, fifo_full, push, pop;
   logic [INPUT_WIDTH-1:0]           head;

   logic [SW-1:0]                    lane_slot [WPW];
   logic [WPW-1:0]                   lane_ok;
   logic                             last_word;
   int                               c_tmp, r_tmp;

   assign start_edge = LOAD_START & ~start_prev;
   assign clr_edge   = CLEAR & ~clr_prev;
   assign param_ok   = (PARAM_R != 4'd0) && (PARAM_R <= R_MAX4) &&
                       (PARAM_S != 4'd0) && (PARAM_S <= S_MAX4);
   assign sh         = ~active_bank;

   // ---------------- write-side FIFO (fall-through head) ----------------
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
   assign push       = fifo_if.FIFO_WR_CMD && !fifo_full && !clr_edge;
   assign pop        = (state == LOAD) && !fifo_empty && !clr_edge;
   assign head       = fifo_mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr] <= fifo_if.FIFO_WR_DATA;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (clr_edge) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
   end

   // Slot addresses for each lane of the head word, stepping row/col instead of dividing.
   always_comb begin
      lane_slot = '{default: '0};
      lane_ok   = '0;
      c_tmp     = int'(c_cnt);
      r_tmp     = int'(r_cnt);
      for (int j = 0; j < WPW; j++) begin
         lane_slot[j] = SW'(r_tmp * MAX_S + c_tmp);
         lane_ok[j]   = (int'(w_idx) + j) < int'(n_lat);
         c_tmp        = c_tmp + 1;
         if (c_tmp == int'(s_lat)) begin
            c_tmp = 0;
            r_tmp = r_tmp + 1;
         end
      end
   end

   assign last_word = (int'(w_idx) + WPW) >= int'(n_lat);

   // ---------------- control FSM and bank storage ----------------
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state        <= IDLE;
         start_prev   <= 1'b0;
         clr_prev     <= 1'b0;
         s_lat        <= '0;
         n_lat        <= '0;
         w_idx        <= '0;
         r_cnt        <= '0;
         c_cnt        <= '0;
         bank         <= '{default: '0};
         active_bank  <= 1'b0;
         shadow_valid <= 1'b0;
         err_param    <= 1'b0;
         load_done    <= 1'b0;
      end else begin
         start_prev <= LOAD_START;
         clr_prev   <= CLEAR;
         load_done  <= 1'b0;
         if (clr_edge) begin
            state        <= IDLE;
            shadow_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_edge) begin
                     if (param_ok) begin
                        s_lat        <= PARAM_S;
                        n_lat        <= IW'(PARAM_R) * IW'(PARAM_S);
                        w_idx        <= '0;
                        r_cnt        <= '0;
                        c_cnt        <= '0;
                        bank[sh]     <= '0;
                        shadow_valid <= 1'b0;
                        err_param    <= 1'b0;
                        state        <= LOAD;
                     end else begin
                        err_param <= 1'b1;
                     end
                  end else if (SWAP && shadow_valid) begin
                     active_bank  <= ~active_bank;
                     shadow_valid <= 1'b0;
                  end
               end
               LOAD: begin
                  if (!fifo_empty) begin
                     for (int j = 0; j < WPW; j++) begin
                        if (lane_ok[j])
                           bank[sh][lane_slot[j]] <= head[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                     end
                     w_idx <= w_idx + IW'(WPW);
                     c_cnt <= 4'(c_tmp);
                     r_cnt <= 4'(r_tmp);
                     if (last_word) begin
                        state        <= IDLE;
                        load_done    <= 1'b1;
                        shadow_valid <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign LOADING            = (state == LOAD);
   assign LOAD_DONE          = load_done;
   assign SHADOW_VALID       = shadow_valid;
   assign ACTIVE_BANK        = active_bank;
   assign ERR_PARAM          = err_param;
   assign WS_RD_DATA         = bank[active_bank];
   assign fifo_if.FIFO_EMPTY = fifo_empty;
   assign fifo_if.FIFO_FULL  = fifo_full;
   assign fifo_if.FIFO_COUNT = fifo_cnt;
endmodule
